// File: rtl/decode_pkg.sv
// Shared opcode, select and FSM state definitions for the decode stage and its table.
package decode_pkg;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_ALUI = 8'hBC;
  localparam logic [7:0] OP_ADD  = 8'h80;
  localparam logic [7:0] OP_SUB  = 8'h81;
  localparam logic [7:0] OP_LD   = 8'hC0;
  localparam logic [7:0] OP_ST   = 8'hC1;
  localparam logic [7:0] OP_FBST = 8'hC2;
  localparam logic [7:0] OP_CALL = 8'hE0;
  localparam logic [7:0] OP_RET  = 8'hE1;

  typedef enum logic [1:0] {
    EX_SEL_ALU = 2'd0,
    EX_SEL_IMM = 2'd1,
    EX_SEL_PC1 = 2'd2
  } ex_sel_e;

  typedef enum logic [1:0] {
    WB_SEL_EX  = 2'd0,
    WB_SEL_MEM = 2'd1,
    WB_SEL_CS  = 2'd2
  } wb_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FULL   = 2'd1,
    ST_SECOND = 2'd2
  } state_e;

endpackage

// File: rtl/decode_table.sv
// Combinational map from (opcode, micro-op index) to the control bundle and illegal flag.
module decode_table
  import decode_pkg::*;
#(
  parameter int OPCODE_WIDTH = 8,
  parameter int RD_PORTS     = 2,
  parameter int WR_PORTS     = 2,
  parameter int SEL_WIDTH    = 4
) (
  input  logic [OPCODE_WIDTH-1:0] opcode_i,
  input  logic                    uop_index_i,
  output logic [RD_PORTS-1:0]     ren_o,
  output logic                    main_mem_o,
  output logic                    frame_buf_o,
  output logic                    call_stack_o,
  output logic [1:0]              mem_wren_o,
  output logic [SEL_WIDTH-1:0]    ex_sel_o,
  output logic [SEL_WIDTH-1:0]    wb_sel_o,
  output logic [WR_PORTS-1:0]     wen_o,
  output logic                    illegal_o,
  output logic                    two_uop_o
);

  localparam int OW = OPCODE_WIDTH;

  always_comb begin
    ren_o        = '0;
    main_mem_o   = 1'b0;
    frame_buf_o  = 1'b0;
    call_stack_o = 1'b0;
    mem_wren_o   = 2'b00;
    ex_sel_o     = SEL_WIDTH'(EX_SEL_ALU);
    wb_sel_o     = SEL_WIDTH'(WB_SEL_EX);
    wen_o        = '0;
    illegal_o    = 1'b0;
    two_uop_o    = 1'b0;
    case (opcode_i)
      OW'(OP_NOP): ;
      OW'(OP_ALUI): begin
        ren_o    = RD_PORTS'(2'b01);
        ex_sel_o = SEL_WIDTH'(EX_SEL_IMM);
        wen_o    = WR_PORTS'(1'b1);
      end
      OW'(OP_ADD), OW'(OP_SUB): begin
        ren_o = RD_PORTS'(2'b11);
        wen_o = WR_PORTS'(1'b1);
      end
      OW'(OP_LD): begin
        ren_o      = RD_PORTS'(2'b01);
        main_mem_o = 1'b1;
        wb_sel_o   = SEL_WIDTH'(WB_SEL_MEM);
        wen_o      = WR_PORTS'(1'b1);
      end
      OW'(OP_ST): begin
        ren_o      = RD_PORTS'(2'b11);
        main_mem_o = 1'b1;
        mem_wren_o = 2'b01;
      end
      OW'(OP_FBST): begin
        ren_o       = RD_PORTS'(2'b11);
        frame_buf_o = 1'b1;
        mem_wren_o  = 2'b10;
      end
      // The second micro-op of CALL/RET is the jump and carries no memory controls.
      OW'(OP_CALL): begin
        two_uop_o = 1'b1;
        if (!uop_index_i) begin
          call_stack_o = 1'b1;
          ex_sel_o     = SEL_WIDTH'(EX_SEL_PC1);
          mem_wren_o   = 2'b10;
        end
      end
      OW'(OP_RET): begin
        two_uop_o = 1'b1;
        if (!uop_index_i) begin
          call_stack_o = 1'b1;
          wb_sel_o     = SEL_WIDTH'(WB_SEL_CS);
        end
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: valid/ready handshake, CALL/RET micro-op sequencing and flush.
module decode_stage
  import decode_pkg::*;
#(
  parameter int INSTR_WIDTH  = 32,
  parameter int OPCODE_WIDTH = 8,
  parameter int RD_PORTS     = 2,
  parameter int WR_PORTS     = 2,
  parameter int SEL_WIDTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_WIDTH-1:0] instruction,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RD_PORTS-1:0]    reg_file_ren,
  output logic                   main_memory_enable,
  output logic                   frame_buffer_enable,
  output logic                   call_stack_enable,
  output logic [1:0]             mem_wren,
  output logic [SEL_WIDTH-1:0]   ex_mem_data_input_sel,
  output logic [SEL_WIDTH-1:0]   mem_wb_data_input_sel,
  output logic [WR_PORTS-1:0]    reg_file_wen,
  output logic                   uop_index,
  output logic                   illegal
);

  state_e                  state_q;
  logic [OPCODE_WIDTH-1:0] opcode_q;
  logic                    out_valid_q;
  logic [RD_PORTS-1:0]     ren_q;
  logic                    main_mem_q;
  logic                    frame_buf_q;
  logic                    call_stack_q;
  logic [1:0]              mem_wren_q;
  logic [SEL_WIDTH-1:0]    ex_sel_q;
  logic [SEL_WIDTH-1:0]    wb_sel_q;
  logic [WR_PORTS-1:0]     wen_q;
  logic                    uop_index_q;
  logic                    illegal_q;

  logic [OPCODE_WIDTH-1:0] table_op_d;
  logic                    table_uop_d;
  logic [RD_PORTS-1:0]     ren_d;
  logic                    main_mem_d;
  logic                    frame_buf_d;
  logic                    call_stack_d;
  logic [1:0]              mem_wren_d;
  logic [SEL_WIDTH-1:0]    ex_sel_d;
  logic [SEL_WIDTH-1:0]    wb_sel_d;
  logic [WR_PORTS-1:0]     wen_d;
  logic                    illegal_d;
  logic                    two_uop_d;
  logic                    accept;

  generate
    if (INSTR_WIDTH > OPCODE_WIDTH) begin : g_upper
      logic unused_upper;
      assign unused_upper = ^instruction[INSTR_WIDTH-1:OPCODE_WIDTH];
    end
  endgenerate

  // While uop1 is pending the table is fed the latched opcode instead of the fetch bus.
  assign table_op_d  = (state_q == ST_SECOND) ? opcode_q : instruction[OPCODE_WIDTH-1:0];
  assign table_uop_d = (state_q == ST_SECOND);

  decode_table #(
    .OPCODE_WIDTH(OPCODE_WIDTH),
    .RD_PORTS    (RD_PORTS),
    .WR_PORTS    (WR_PORTS),
    .SEL_WIDTH   (SEL_WIDTH)
  ) u_table (
    .opcode_i    (table_op_d),
    .uop_index_i (table_uop_d),
    .ren_o       (ren_d),
    .main_mem_o  (main_mem_d),
    .frame_buf_o (frame_buf_d),
    .call_stack_o(call_stack_d),
    .mem_wren_o  (mem_wren_d),
    .ex_sel_o    (ex_sel_d),
    .wb_sel_o    (wb_sel_d),
    .wen_o       (wen_d),
    .illegal_o   (illegal_d),
    .two_uop_o   (two_uop_d)
  );

  assign in_ready = !rst && !flush && (state_q != ST_SECOND) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Flush only invalidates; the bundle fields themselves change solely on a load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      opcode_q     <= '0;
      out_valid_q  <= 1'b0;
      ren_q        <= '0;
      main_mem_q   <= 1'b0;
      frame_buf_q  <= 1'b0;
      call_stack_q <= 1'b0;
      mem_wren_q   <= 2'b00;
      ex_sel_q     <= '0;
      wb_sel_q     <= '0;
      wen_q        <= '0;
      uop_index_q  <= 1'b0;
      illegal_q    <= 1'b0;
    end else if (flush) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
    end else if (state_q == ST_SECOND) begin
      if (out_ready) begin
        ren_q        <= ren_d;
        main_mem_q   <= main_mem_d;
        frame_buf_q  <= frame_buf_d;
        call_stack_q <= call_stack_d;
        mem_wren_q   <= mem_wren_d;
        ex_sel_q     <= ex_sel_d;
        wb_sel_q     <= wb_sel_d;
        wen_q        <= wen_d;
        illegal_q    <= illegal_d;
        uop_index_q  <= 1'b1;
        state_q      <= ST_FULL;
      end
    end else if (accept) begin
      ren_q        <= ren_d;
      main_mem_q   <= main_mem_d;
      frame_buf_q  <= frame_buf_d;
      call_stack_q <= call_stack_d;
      mem_wren_q   <= mem_wren_d;
      ex_sel_q     <= ex_sel_d;
      wb_sel_q     <= wb_sel_d;
      wen_q        <= wen_d;
      illegal_q    <= illegal_d;
      uop_index_q  <= 1'b0;
      opcode_q     <= instruction[OPCODE_WIDTH-1:0];
      out_valid_q  <= 1'b1;
      state_q      <= two_uop_d ? ST_SECOND : ST_FULL;
    end else if (out_ready) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid             = out_valid_q;
  assign reg_file_ren          = ren_q;
  assign main_memory_enable    = main_mem_q;
  assign frame_buffer_enable   = frame_buf_q;
  assign call_stack_enable     = call_stack_q;
  assign mem_wren              = mem_wren_q;
  assign ex_mem_data_input_sel = ex_sel_q;
  assign mem_wb_data_input_sel = wb_sel_q;
  assign reg_file_wen          = wen_q;
  assign uop_index             = uop_index_q;
  assign illegal               = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a randomized scoreboard run.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instruction = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  reg_file_ren;
  logic        main_memory_enable;
  logic        frame_buffer_enable;
  logic        call_stack_enable;
  logic [1:0]  mem_wren;
  logic [3:0]  ex_mem_data_input_sel;
  logic [3:0]  mem_wb_data_input_sel;
  logic [1:0]  reg_file_wen;
  logic        uop_index;
  logic        illegal;
  logic [18:0] dut_bundle;

  int checks = 0;
  int fails = 0;

  decode_stage dut (
    .clk                  (clk),
    .rst                  (rst),
    .flush                (flush),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .instruction          (instruction),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .reg_file_ren         (reg_file_ren),
    .main_memory_enable   (main_memory_enable),
    .frame_buffer_enable  (frame_buffer_enable),
    .call_stack_enable    (call_stack_enable),
    .mem_wren             (mem_wren),
    .ex_mem_data_input_sel(ex_mem_data_input_sel),
    .mem_wb_data_input_sel(mem_wb_data_input_sel),
    .reg_file_wen         (reg_file_wen),
    .uop_index            (uop_index),
    .illegal              (illegal)
  );

  always #5 clk = ~clk;

  assign dut_bundle = {reg_file_ren, main_memory_enable, frame_buffer_enable, call_stack_enable,
                       mem_wren, ex_mem_data_input_sel, mem_wb_data_input_sel, reg_file_wen,
                       uop_index, illegal};

  // Reference decode written straight from the opcode table, packed like dut_bundle.
  function automatic logic [18:0] exp_bundle(input logic [7:0] op, input logic uop);
    logic [1:0] ren, mw, wen;
    logic       mm, fb, cs, ill;
    logic [3:0] ex, wb;
    ren = 0; mw = 0; wen = 0; mm = 0; fb = 0; cs = 0; ill = 0; ex = 0; wb = 0;
    case (op)
      8'h00: ;
      8'hBC: begin ren = 2'b01; ex = 4'd1; wen = 2'b01; end
      8'h80, 8'h81: begin ren = 2'b11; wen = 2'b01; end
      8'hC0: begin ren = 2'b01; mm = 1; wb = 4'd1; wen = 2'b01; end
      8'hC1: begin ren = 2'b11; mm = 1; mw = 2'b01; end
      8'hC2: begin ren = 2'b11; fb = 1; mw = 2'b10; end
      8'hE0: if (!uop) begin cs = 1; ex = 4'd2; mw = 2'b10; end
      8'hE1: if (!uop) begin cs = 1; wb = 4'd2; end
      default: ill = 1;
    endcase
    return {ren, mm, fb, cs, mw, ex, wb, wen, uop, ill};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || dut_bundle !== '0) begin
      fails++;
      $display("[TB] FAIL reset_held: valid=%b ready=%b bundle=%h, expected 0 0 0", out_valid, in_ready, dut_bundle);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || dut_bundle !== '0) begin
      fails++;
      $display("[TB] FAIL reset_release: valid=%b ready=%b bundle=%h, expected 0 1 0", out_valid, in_ready, dut_bundle);
    end
  endtask

  task automatic test_stream();
    logic [7:0] ops[3];
    ops = '{8'h80, 8'h81, 8'hC0};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instruction = {24'hA5A5A5, ops[i]};
      tick();
      checks++;
      if (out_valid !== 1'b1 || dut_bundle !== exp_bundle(ops[i], 1'b0)) begin
        fails++;
        $display("[TB] FAIL stream_beat%0d: valid=%b bundle=%h, expected 1 %h", i, out_valid, dut_bundle, exp_bundle(ops[i], 1'b0));
      end
    end
    checks++;
    if (reg_file_ren !== 2'b01 || main_memory_enable !== 1'b1 || mem_wb_data_input_sel !== 4'd1 || reg_file_wen !== 2'b01) begin
      fails++;
      $display("[TB] FAIL stream_load_fields: ren=%b mm=%b wb=%0d wen=%b, expected 01 1 1 01", reg_file_ren, main_memory_enable, mem_wb_data_input_sel, reg_file_wen);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL stream_drain: valid=%b, expected 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    int beats;
    out_ready   = 1'b0;
    in_valid    = 1'b1;
    instruction = 32'h0000_0080;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || dut_bundle !== exp_bundle(8'h80, 1'b0)) begin
        fails++;
        $display("[TB] FAIL bp_hold%0d: valid=%b ready=%b bundle=%h, expected 1 0 %h", i, out_valid, in_ready, dut_bundle, exp_bundle(8'h80, 1'b0));
      end
      tick();
    end
    out_ready = 1'b1;
    beats = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (out_valid === 1'b1) beats++;
      tick();
    end
    checks++;
    if (beats != 1) begin
      fails++;
      $display("[TB] FAIL bp_beats: delivered %0d, expected 1", beats);
    end
  endtask

  task automatic test_call();
    out_ready   = 1'b1;
    in_valid    = 1'b1;
    instruction = 32'h1234_00E0;
    tick();
    instruction = 32'h0000_0080;
    #1;
    checks++;
    if (out_valid !== 1'b1 || call_stack_enable !== 1'b1 || mem_wren !== 2'b10 ||
        ex_mem_data_input_sel !== 4'd2 || uop_index !== 1'b0) begin
      fails++;
      $display("[TB] FAIL call_uop0: valid=%b cs=%b wren=%b ex=%0d uop=%b, expected 1 1 10 2 0", out_valid, call_stack_enable, mem_wren, ex_mem_data_input_sel, uop_index);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL call_ready_uop0: in_ready=%b, expected 0", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || dut_bundle !== exp_bundle(8'hE0, 1'b1)) begin
      fails++;
      $display("[TB] FAIL call_uop1: valid=%b bundle=%h, expected 1 %h", out_valid, dut_bundle, exp_bundle(8'hE0, 1'b1));
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || dut_bundle !== exp_bundle(8'h80, 1'b0)) begin
      fails++;
      $display("[TB] FAIL call_next_add: valid=%b bundle=%h, expected 1 %h", out_valid, dut_bundle, exp_bundle(8'h80, 1'b0));
    end
    tick();
  endtask

  task automatic test_flush();
    out_ready   = 1'b0;
    in_valid    = 1'b1;
    instruction = 32'h0000_00E1;
    tick();
    in_valid    = 1'b1;
    instruction = 32'h0000_0081;
    flush       = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL flush_ready: in_ready=%b, expected 0", in_ready);
    end
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL flush_idle: valid=%b ready=%b, expected 0 1", out_valid, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL flush_no_uop1: valid=%b, expected 0", out_valid);
    end
    in_valid    = 1'b1;
    instruction = 32'h0000_0080;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || dut_bundle !== exp_bundle(8'h80, 1'b0)) begin
      fails++;
      $display("[TB] FAIL flush_then_add: valid=%b bundle=%h, expected 1 %h", out_valid, dut_bundle, exp_bundle(8'h80, 1'b0));
    end
    tick();
  endtask

  task automatic test_illegal_and_reset();
    out_ready   = 1'b1;
    in_valid    = 1'b1;
    instruction = 32'hFFFF_FF7F;
    tick();
    checks++;
    if (out_valid !== 1'b1 || dut_bundle !== exp_bundle(8'h7F, 1'b0) || illegal !== 1'b1) begin
      fails++;
      $display("[TB] FAIL illegal_7f: valid=%b bundle=%h, expected 1 %h", out_valid, dut_bundle, exp_bundle(8'h7F, 1'b0));
    end
    out_ready   = 1'b0;
    instruction = 32'h0000_00E0;
    tick();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || dut_bundle !== '0 || in_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL async_reset: valid=%b ready=%b bundle=%h, expected 0 0 0", out_valid, in_ready, dut_bundle);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_ready: in_ready=%b, expected 1", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_drops_uop1: valid=%b, expected 0", out_valid);
    end
  endtask

  // Scoreboard run: the queue holds every beat still owed to execute, in order.
  task automatic test_random();
    logic [18:0] q[$];
    logic [7:0]  ops[9];
    logic [7:0]  op;
    logic [31:0] word;
    logic        exp_ready;
    ops = '{8'h00, 8'hBC, 8'h80, 8'h81, 8'hC0, 8'hC1, 8'hC2, 8'hE0, 8'hE1};
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    tick();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) op = 8'($urandom_range(0, 255));
      else op = ops[$urandom_range(0, 8)];
      word        = $urandom();
      word[7:0]   = op;
      instruction = word;
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 15) == 0);
      #1;
      exp_ready = !flush && (q.size() < 2) && (q.size() == 0 || out_ready);
      checks++;
      if (out_valid !== (q.size() != 0)) begin
        fails++;
        $display("[TB] FAIL rand_valid[%0d]: valid=%b, expected %b", i, out_valid, q.size() != 0);
      end
      checks++;
      if (in_ready !== exp_ready) begin
        fails++;
        $display("[TB] FAIL rand_ready[%0d]: in_ready=%b, expected %b", i, in_ready, exp_ready);
      end
      if (q.size() != 0) begin
        checks++;
        if (dut_bundle !== q[0]) begin
          fails++;
          $display("[TB] FAIL rand_bundle[%0d]: bundle=%h, expected %h", i, dut_bundle, q[0]);
        end
      end
      if (flush) q.delete();
      else if (out_ready && q.size() != 0) void'(q.pop_front());
      if (in_valid && exp_ready) begin
        q.push_back(exp_bundle(op, 1'b0));
        if (op == 8'hE0 || op == 8'hE1) q.push_back(exp_bundle(op, 1'b1));
      end
      tick();
    end
    in_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_call();
    test_flush();
    test_illegal_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
